// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/decode/execute sequencer with ROM wait-state timeout
module cpu_sequencer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       rom_req,
    output logic [3:0] rom_addr,
    input  logic       rom_ack,
    input  logic [7:0] rom_data,
    output logic [7:0] ir,
    input  logic       dl0,
    input  logic       dl1,
    input  logic       dl2,
    input  logic       dl3,
    input  logic       dhlt,
    input  logic [3:0] alu_y,
    input  logic       alu_c,
    output logic [2:0] ld,
    output logic [3:0] pc,
    output logic       zf,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] wait_cnt;
    logic       timeout;

    // Widened compare so ACK_TIMEOUT=255 does not overflow the 8-bit counter.
    assign timeout  = (({1'b0, wait_cnt} + 9'd1) == 9'(ACK_TIMEOUT));
    assign rom_addr = pc;

    always_comb begin
        state_n = state;
        rom_req = 1'b0;
        ld      = 3'b000;
        halted  = 1'b0;
        fault   = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_n = S_FETCH;
            end
            S_FETCH: begin
                rom_req = 1'b1;
                if (rom_ack)      state_n = S_DECODE;
                else if (timeout) state_n = S_FAULT;
            end
            S_DECODE: begin
                state_n = dhlt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                ld      = {dl2, dl1, dl0};
                state_n = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            pc       <= 4'd0;
            ir       <= 8'h00;
            zf       <= 1'b0;
        end else begin
            state <= state_n;
            if (state != S_FETCH && state_n == S_FETCH)
                wait_cnt <= 8'd0;
            else if (state == S_FETCH && !rom_ack)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == S_FETCH && rom_ack)
                ir <= rom_data;
            if (state == S_EXEC) begin
                zf <= alu_c;
                pc <= dl3 ? alu_y : pc + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - randomized bench against an instruction-level reference model
module tb_cpu_sequencer;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       rom_req;
    logic [3:0] rom_addr;
    logic       rom_ack;
    logic [7:0] rom_data;
    logic [7:0] ir;
    logic       dl0, dl1, dl2, dl3, dhlt;
    logic [3:0] alu_y;
    logic       alu_c;
    logic [2:0] ld;
    logic [3:0] pc;
    logic       zf;
    logic       halted;
    logic       fault;

    cpu_sequencer #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .ir(ir), .dl0(dl0), .dl1(dl1), .dl2(dl2), .dl3(dl3), .dhlt(dhlt),
        .alu_y(alu_y), .alu_c(alu_c), .ld(ld), .pc(pc), .zf(zf),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase of the current instruction plus architectural registers.
    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_HALT = 4, P_FAULT = 5;
    int m_phase, m_waited, m_pc, m_ir, m_zf;

    task automatic model_reset();
        m_phase = P_IDLE; m_waited = 0; m_pc = 0; m_ir = 0; m_zf = 0;
    endtask

    task automatic model_check();
        int exp_ld;
        exp_ld = (m_phase == P_EXEC) ? (4 * int'(dl2) + 2 * int'(dl1) + int'(dl0)) : 0;
        chk("rom_req", int'(rom_req), int'(m_phase == P_FETCH));
        chk("rom_addr", int'(rom_addr), m_pc);
        chk("pc", int'(pc), m_pc);
        chk("ir", int'(ir), m_ir);
        chk("zf", int'(zf), m_zf);
        chk("ld", int'(ld), exp_ld);
        chk("halted", int'(halted), int'(m_phase == P_HALT));
        chk("fault", int'(fault), int'(m_phase == P_FAULT));
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_phase)
            P_IDLE: if (run) begin m_phase = P_FETCH; m_waited = 0; end
            P_FETCH: begin
                if (rom_ack) begin
                    m_ir = int'(rom_data);
                    m_phase = P_DECODE;
                end else begin
                    m_waited++;
                    if (m_waited >= TO) m_phase = P_FAULT;
                end
            end
            P_DECODE: m_phase = dhlt ? P_HALT : P_EXEC;
            P_EXEC: begin
                m_zf = int'(alu_c);
                m_pc = dl3 ? int'(alu_y) : (m_pc + 1) % 16;
                m_phase = run ? P_FETCH : P_IDLE;
                m_waited = 0;
            end
            default: ;
        endcase
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; rom_ack = 1'b1; rom_data = 8'hA5;
        dl0 = 1'b1; dl1 = 1'b0; dl2 = 1'b0; dl3 = 1'b0; dhlt = 1'b0;
        alu_y = 4'd9; alu_c = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        chk("reset_state", int'({rom_req, halted, fault, zf, ld, pc, ir}), 0);
        model_check();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (m_phase == P_HALT || m_phase == P_FAULT)
                rst_n = ($urandom % 6) != 0;
            else
                rst_n = ($urandom % 80) != 0;
            run      = ($urandom % 8) != 0;
            rom_ack  = ($urandom % 5) < 2;
            rom_data = 8'($urandom);
            dl0      = 1'($urandom);
            dl1      = 1'($urandom);
            dl2      = 1'($urandom);
            dl3      = ($urandom % 4) == 0;
            dhlt     = ($urandom % 10) == 0;
            alu_y    = 4'($urandom);
            alu_c    = 1'($urandom);
            #1;
            model_check();
            model_step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have one parameter: ACK_TIMEOUT, default 15, meaning consecutive FETCH cycles without ROM_ACK before FAULT (range 1..255).
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RST_N  input  1  reset; synchronous, active-low.
REQ-004 RUN  input  1  1 = fetch/execute permitted; sampled in IDLE and at end of EXEC.
REQ-005 ROM_REQ  output  1  instruction-fetch request.
REQ-006 ROM_ADDR  output  4  fetch address; equals PC.
REQ-007 ROM_ACK  input  1  ROM_DATA valid this cycle.
REQ-008 ROM_DATA  input  8  instruction byte.
REQ-009 IR  output  8  instruction register; drives the decoder A input.
REQ-010 DL0, DL1, DL2, DL3, DHLT  input  1 each  decoder load/halt decodes for IR.
REQ-011 ALU_Y  input  4  ALU result; jump target when DL3=1.
REQ-012 ALU_C  input  1  ALU carry-out.
REQ-013 LD  output  3  one-cycle load strobes: LD[0]=DL0, LD[1]=DL1, LD[2]=DL2.
REQ-014 PC  output  4  program counter.
REQ-015 ZF  output  1  flag register; feeds decoder ZF.
REQ-016 HALTED  output  1  1 while in HALT.
REQ-017 FAULT  output  1  1 while in FAULT.

Function
REQ-018 The state machine SHALL have states IDLE, FETCH, DECODE, EXEC, HALT and FAULT.
REQ-019 IDLE: ROM_REQ=0, LD=0; RUN=1 -> FETCH next cycle, else remain.
REQ-020 FETCH: ROM_REQ=1, ROM_ADDR=PC; ROM_ACK=1 -> IR<=ROM_DATA and go to DECODE; ROM_ACK is accepted in the first FETCH cycle (zero-wait ROM allowed).
REQ-021 FETCH timeout counter (8-bit) SHALL clear on entry to FETCH and increment each FETCH cycle with ROM_ACK=0; when it reaches ACK_TIMEOUT -> FAULT next cycle.
REQ-022 ROM_ACK=1 in the cycle the counter reaches ACK_TIMEOUT SHALL win: go to DECODE, no FAULT.
REQ-023 ROM_ACK outside FETCH SHALL be ignored; IR changes only on accepted ACK.
REQ-024 DECODE: one settle cycle, ROM_REQ=0, LD=0; DHLT=1 -> HALT, else EXEC.
REQ-025 EXEC: exactly one cycle; LD={DL2,DL1,DL0}; ZF<=ALU_C; PC<=ALU_Y if DL3=1, else PC+1 modulo 16 (15 -> 0).
REQ-026 After EXEC: RUN=1 -> FETCH, RUN=0 -> IDLE.
REQ-027 Latency SHALL be 3 cycles per instruction with zero-wait ROM (FETCH, DECODE, EXEC), plus one cycle per ROM wait state.
REQ-028 RUN deasserted during FETCH/DECODE SHALL NOT abort; the current instruction completes and the machine then enters IDLE.
REQ-029 HALT: PC, ZF and IR unchanged, LD=0, ROM_REQ=0, HALTED=1; exit only by reset.
REQ-030 FAULT: PC, ZF and IR unchanged, LD=0, ROM_REQ=0, FAULT=1; exit only by reset.
REQ-031 LD SHALL be nonzero only in EXEC; ROM_REQ=1 only in FETCH.

Reset
REQ-032 When RST_N=0 at a rising edge, the next state SHALL be IDLE with PC=0, IR=0x00, ZF=0, LD=0, ROM_REQ=0, HALTED=0, FAULT=0 and the timeout counter=0, regardless of the current state (including mid-FETCH, HALT, FAULT).
REQ-033 Reset SHALL take priority over ROM_ACK and RUN in the same cycle.

Verification
REQ-034 Zero-wait run: RUN=1, ROM_ACK tied 1, ROM_DATA=0x30, DL0=1, ALU_C=1 -> ROM_REQ every 3rd cycle, LD=001 one cycle per instruction, ZF=1, PC 0,1,2,... wraps 15->0.
REQ-035 Jump: IR=0xF5, DL3=1, ALU_Y=5 -> in EXEC LD=000 and PC=5 next cycle; with DL3=0 -> PC=old PC+1.
REQ-036 Wait states/timeout: ACK_TIMEOUT=4, ACK after 3 idle cycles -> DECODE, no FAULT; ACK in the 4th cycle -> accepted; no ACK for 4 cycles -> FAULT=1 and ROM_REQ=0 stays until reset.
REQ-037 Halt: ROM_DATA=0x60, DHLT=1 -> HALTED=1 two cycles after ACK; PC frozen; toggling RUN has no effect.
REQ-038 RUN dropped mid-FETCH with ACK two cycles later -> the instruction executes (LD pulse), then IDLE; RUN=1 again -> FETCH at PC+1.
REQ-039 RST_N=0 for one cycle during FETCH with ROM_ACK=1 -> IDLE, PC=0, IR=0x00, ACK not accepted.
